// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_core TX path among NUM_REQ byte streams,
// locking the grant per packet. Optional idle watchdog: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_BITS    = 8,
  parameter int PULSE_GAP    = 2,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             grant,
  output logic [DATA_BITS-1:0]           uart_data,
  output logic                           uart_pulse_tx,
  input  logic                           uart_tx_full,
  output logic                           busy,
  output logic                           timeout_flag
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int IDX_W1 = IDX_W + 1;
  localparam int GAP_W  = $clog2(PULSE_GAP + 1);

  typedef enum logic [1:0] {IDLE, LOCK, PULSE, GAP} state_t;

  state_t                 state_reg, state_next;
  logic [IDX_W-1:0]       owner_reg, owner_next;
  logic [IDX_W-1:0]       rr_reg, rr_next;
  logic [IDX_W-1:0]       pick;
  logic [IDX_W-1:0]       rr_after;
  logic [NUM_REQ-1:0]     grant_reg, grant_next;
  logic [NUM_REQ-1:0]     ready_reg, ready_next;
  logic [DATA_BITS-1:0]   data_reg, data_next;
  logic                   last_reg, last_next;
  logic                   pulse_reg, pulse_next;
  logic                   busy_reg, busy_next;
  logic [GAP_W-1:0]       gap_reg, gap_next;
  logic [DATA_BITS-1:0]   req_bytes [NUM_REQ];

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  logic [IDLE_W-1:0]      idle_reg, idle_next;
  logic                   tflag_reg, tflag_next;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign req_bytes[gi] = req_data[gi*DATA_BITS +: DATA_BITS];
    end
  endgenerate

  assign rr_after = (owner_reg == IDX_W'(NUM_REQ - 1)) ? '0 : owner_reg + IDX_W'(1);

  // Scan downward so the requester closest to rr_reg (upward, wrapping) wins last.
  always_comb begin : arb_pick
    logic [IDX_W1-1:0] idx;
    idx  = '0;
    pick = rr_reg;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_reg} + IDX_W1'(k);
      if (idx >= IDX_W1'(NUM_REQ)) idx = idx - IDX_W1'(NUM_REQ);
      if (req_valid[idx[IDX_W-1:0]]) pick = idx[IDX_W-1:0];
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    rr_next    = rr_reg;
    grant_next = grant_reg;
    ready_next = '0;
    data_next  = data_reg;
    last_next  = last_reg;
    pulse_next = 1'b0;
    gap_next   = gap_reg;
`ifdef UART_TX_ARB_TIMEOUT_EN
    idle_next  = '0;
    tflag_next = tflag_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (|req_valid) begin
          owner_next       = pick;
          grant_next       = '0;
          grant_next[pick] = 1'b1;
          state_next       = LOCK;
        end
      end
      LOCK: begin
        if (req_valid[owner_reg] && !uart_tx_full) begin
          ready_next[owner_reg] = 1'b1;
          data_next             = req_bytes[owner_reg];
          last_next             = req_last[owner_reg];
          state_next            = PULSE;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        // A full FIFO with a valid owner is back-pressure, not inactivity.
        else if (!req_valid[owner_reg]) begin
          if (idle_reg == IDLE_W'(IDLE_TIMEOUT - 1)) begin
            grant_next = '0;
            rr_next    = rr_after;
            tflag_next = 1'b1;
            state_next = IDLE;
          end else begin
            idle_next = idle_reg + IDLE_W'(1);
          end
        end
`endif
      end
      PULSE: begin
        pulse_next = 1'b1;
        gap_next   = '0;
        state_next = GAP;
      end
      GAP: begin
        if (gap_reg == GAP_W'(PULSE_GAP - 1)) begin
          if (last_reg) begin
            grant_next = '0;
            rr_next    = rr_after;
            state_next = IDLE;
          end else begin
            state_next = LOCK;
          end
        end else begin
          gap_next = gap_reg + GAP_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      rr_reg    <= '0;
      grant_reg <= '0;
      ready_reg <= '0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
      pulse_reg <= 1'b0;
      busy_reg  <= 1'b0;
      gap_reg   <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      idle_reg  <= '0;
      tflag_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      rr_reg    <= rr_next;
      grant_reg <= grant_next;
      ready_reg <= ready_next;
      data_reg  <= data_next;
      last_reg  <= last_next;
      pulse_reg <= pulse_next;
      busy_reg  <= busy_next;
      gap_reg   <= gap_next;
`ifdef UART_TX_ARB_TIMEOUT_EN
      idle_reg  <= idle_next;
      tflag_reg <= tflag_next;
`endif
    end
  end

  assign grant         = grant_reg;
  assign req_ready     = ready_reg;
  assign uart_data     = data_reg;
  assign uart_pulse_tx = pulse_reg;
  assign busy          = busy_reg;

`ifdef UART_TX_ARB_TIMEOUT_EN
  assign timeout_flag = tflag_reg;
`else
  // No watchdog: the flag can never set (the comparison is constant false).
  assign timeout_flag = (IDLE_TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, PULSE_GAP=2, IDLE_TIMEOUT=16).
// Honours UART_TX_ARB_TIMEOUT_EN for the idle-owner scenario.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DB = 8;
  localparam int PG = 2;
  localparam int IT = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DB-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    grant;
  logic [DB-1:0]   uart_data;
  logic            uart_pulse_tx;
  logic            uart_tx_full;
  logic            busy;
  logic            timeout_flag;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(
    .NUM_REQ(N), .DATA_BITS(DB), .PULSE_GAP(PG), .IDLE_TIMEOUT(IT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant),
    .uart_data(uart_data), .uart_pulse_tx(uart_pulse_tx),
    .uart_tx_full(uart_tx_full), .busy(busy), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (uart_pulse_tx) $display("tx byte %02h grant %b", uart_data, grant);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_byte(input int o, input logic [DB-1:0] b, input logic l);
    req_data[o*DB +: DB] = b;
    req_last[o]          = l;
    req_valid[o]         = 1'b1;
  endtask

  // From an IDLE cycle with requests applied: expect owner o locked next cycle.
  task automatic arb(input int o);
    step();
    chk("arb_grant", 32'(grant), 32'(1) << o);
    chk("arb_busy", 32'(busy), 32'd1);
    chk("arb_nopulse", 32'(uart_pulse_tx), 32'd0);
    chk("arb_noready", 32'(req_ready), 32'd0);
  endtask

  // From a LOCK cycle where owner o presents byte b: accept, pulse, gap, then LOCK or IDLE.
  task automatic xfer(input int o, input logic [DB-1:0] b, input logic l);
    step();
    chk("accept_ready", 32'(req_ready), 32'(1) << o);
    chk("accept_data", 32'(uart_data), 32'(b));
    chk("accept_nopulse", 32'(uart_pulse_tx), 32'd0);
    req_valid[o] = 1'b0;
    step();
    chk("pulse_high", 32'(uart_pulse_tx), 32'd1);
    chk("pulse_data", 32'(uart_data), 32'(b));
    chk("pulse_noready", 32'(req_ready), 32'd0);
    step();
    chk("gap_low", 32'(uart_pulse_tx), 32'd0);
    chk("gap_data", 32'(uart_data), 32'(b));
    chk("gap_grant", 32'(grant), 32'(1) << o);
    step();
    chk("after_low", 32'(uart_pulse_tx), 32'd0);
    chk("after_grant", 32'(grant), l ? 32'd0 : (32'(1) << o));
    chk("after_busy", 32'(busy), l ? 32'd0 : 32'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};
    rst          = 1'b1;
    req_valid    = '0;
    req_data     = '0;
    req_last     = '0;
    uart_tx_full = 1'b0;

    // Reset state and quiet idle.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        32'({req_ready, grant, uart_data, uart_pulse_tx, busy, timeout_flag}), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      chk("idle_quiet", 32'({grant, uart_pulse_tx, busy, req_ready}), 32'd0);
    end

    // Requester 1: three-byte packet, pulses every 4 cycles.
    set_byte(1, 8'h41, 1'b0);
    arb(1);
    xfer(1, 8'h41, 1'b0);
    set_byte(1, 8'h42, 1'b0);
    xfer(1, 8'h42, 1'b0);
    set_byte(1, 8'h43, 1'b1);
    xfer(1, 8'h43, 1'b1);

    // rr pointer now 2: with 1 and 2 requesting, 2 wins, then 1.
    set_byte(1, 8'h51, 1'b1);
    set_byte(2, 8'h62, 1'b1);
    arb(2);
    xfer(2, 8'h62, 1'b1);
    arb(1);
    xfer(1, 8'h51, 1'b1);

    // After reset, 0 and 2 simultaneously: 0 then 2.
    pulse_reset();
    set_byte(0, 8'hA0, 1'b1);
    set_byte(2, 8'hA2, 1'b1);
    arb(0);
    xfer(0, 8'hA0, 1'b1);
    arb(2);
    xfer(2, 8'hA2, 1'b1);

    // After reset, all requesting continuously: 0,1,2,3,0.
    pulse_reset();
    for (int o = 0; o < N; o++) set_byte(o, 8'(8'hB0 + o), 1'b1);
    for (int i = 0; i < 5; i++) begin
      arb(order[i]);
      xfer(order[i], 8'(8'hB0 + order[i]), 1'b1);
      if (i < 4) set_byte(order[i], 8'(8'hB0 + order[i]), 1'b1);
    end
    req_valid = '0;

    // FIFO full holds owner 3 off; accept then pulse once it clears.
    uart_tx_full = 1'b1;
    set_byte(3, 8'h77, 1'b1);
    arb(3);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("full_noready", 32'(req_ready), 32'd0);
      chk("full_nopulse", 32'(uart_pulse_tx), 32'd0);
      chk("full_grant", 32'(grant), 32'b1000);
    end
    uart_tx_full = 1'b0;
    xfer(3, 8'h77, 1'b1);

    // Reset during GAP of owner 0 with requester 1 waiting.
    set_byte(0, 8'h10, 1'b0);
    arb(0);
    set_byte(1, 8'h20, 1'b1);
    step();
    chk("rstpkt_ready", 32'(req_ready), 32'b0001);
    set_byte(0, 8'h11, 1'b1);
    step();
    chk("rstpkt_pulse", 32'(uart_pulse_tx), 32'd1);
    step();
    chk("rstpkt_gap", 32'(uart_pulse_tx), 32'd0);
    rst = 1'b1;
    #2;
    chk("async_reset_outputs",
        32'({req_ready, grant, uart_data, uart_pulse_tx, busy, timeout_flag}), 32'd0);
    step();
    rst = 1'b0;
    chk("post_reset_quiet", 32'({grant, uart_pulse_tx, busy, req_ready}), 32'd0);
    arb(0);
    xfer(0, 8'h11, 1'b1);
    arb(1);
    xfer(1, 8'h20, 1'b1);

    // Owner 2 sends a non-last byte then goes silent; requester 3 waits.
    set_byte(2, 8'h30, 1'b0);
    arb(2);
    set_byte(3, 8'h40, 1'b1);
    xfer(2, 8'h30, 1'b0);
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int i = 1; i < IT; i++) begin
      step();
      chk("to_hold_grant", 32'(grant), 32'b0100);
      chk("to_hold_flag", 32'(timeout_flag), 32'd0);
    end
    step();
    chk("to_release_grant", 32'(grant), 32'd0);
    chk("to_release_flag", 32'(timeout_flag), 32'd1);
    chk("to_release_busy", 32'(busy), 32'd0);
    arb(3);
    xfer(3, 8'h40, 1'b1);
    chk("to_flag_sticky", 32'(timeout_flag), 32'd1);
    pulse_reset();
    chk("to_flag_reset", 32'(timeout_flag), 32'd0);
`else
    for (int i = 0; i < 40; i++) begin
      step();
      chk("hold_grant", 32'(grant), 32'b0100);
      chk("hold_flag", 32'(timeout_flag), 32'd0);
      chk("hold_nopulse", 32'(uart_pulse_tx), 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter sharing one uart_core TX path among NUM_REQ byte-stream requesters.
- Grant is locked per packet: the owner holds the UART until it sends a byte flagged last.
- Each accepted byte becomes a clean, isolated pulse_tx strobe with stable data_in. The strobe is spaced so the core's edge-detecting single pulser registers exactly one write per byte.
- Sits between application sources (debug printers, telemetry, command responder) and uart_core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_BITS, 8, byte width; must match uart_core DATA_BITS.
- PULSE_GAP, 2, cycles uart_pulse_tx is held low after each strobe (min 1).
- IDLE_TIMEOUT, 1024, cycles of owner inactivity before forced release (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a byte on its slice of req_data
- req_data  in  NUM_REQ*DATA_BITS  byte for requester i at bits [i*DATA_BITS +: DATA_BITS]
- req_last  in  NUM_REQ  byte of requester i is the last of its packet
- req_ready  out  NUM_REQ  one-cycle accept strobe per requester
- grant  out  NUM_REQ  one-hot current owner; all zero when unlocked
- uart_data  out  DATA_BITS  to uart_core data_in
- uart_pulse_tx  out  1  to uart_core pulse_tx
- uart_tx_full  in  1  from uart_core tx_full
- busy  out  1  high whenever state is not IDLE
- timeout_flag  out  1  sticky forced-release indicator (optional feature only)

Behaviour:
- Reset (asynchronous, rst high):
  - State = IDLE; rr pointer = 0.
  - grant, req_ready, uart_data, uart_pulse_tx, busy, timeout_flag all 0.
  - Reset mid-packet drops the lock immediately. No partial strobe is produced after rst deasserts.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- State machine: IDLE -> LOCK -> PULSE -> GAP -> (LOCK | IDLE).
- IDLE:
  - If any req_valid is set, select the first set bit scanning upward from rr pointer, wrapping modulo NUM_REQ.
  - Set grant one-hot next cycle and enter LOCK. Arbitration costs 1 cycle.
- LOCK:
  - If req_valid[owner] is high and uart_tx_full is low, assert req_ready[owner] for exactly 1 cycle (cycle T).
  - Capture req_data slice into uart_data and req_last into an internal last_r, then go to PULSE.
  - If the owner is not valid or the FIFO is full: wait, holding the grant. The owner is never skipped mid-packet.
- PULSE: uart_pulse_tx = 1 for exactly one cycle (T+1). uart_data is stable from T+1 until the next accept.
- GAP:
  - uart_pulse_tx = 0 for PULSE_GAP cycles (counter, width clog2(PULSE_GAP+1)).
  - Then: if last_r, clear grant, set rr pointer = owner+1 (wrap), and go to IDLE. Otherwise return to LOCK.
- Throughput: at most 1 byte per (2 + PULSE_GAP) cycles while locked. A new packet additionally pays the 1-cycle IDLE arbitration.
- Requests arriving while locked are ignored until release. Simultaneous requests resolve by rr pointer order.
- req_valid deasserting in LOCK is legal; the lock persists.
- uart_tx_full rising during PULSE/GAP does not cancel the in-flight strobe; it only gates the next accept.
- req_last with a zero-length packet is impossible: every accept carries a byte.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - An idle counter runs in LOCK while req_valid[owner] is low; it resets on any accept or on a state change.
  - Reaching IDLE_TIMEOUT forces release (grant cleared, rr pointer = owner+1, IDLE) and sets timeout_flag sticky until rst.
  - uart_tx_full being high does not count as owner idle.
- Undefined: no counter. Lock is held indefinitely. timeout_flag is tied to 0.

Test Plan:
- Reset release, req_valid=0 -> grant=0, uart_pulse_tx=0, busy=0 for 100 cycles.
- Requester 1 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), PULSE_GAP=2:
  - Pulses every 4 cycles with uart_data = 0x41,0x42,0x43 on the pulse cycles.
  - Grant releases after the third GAP; rr pointer = 2.
- Requesters 0 and 2 valid simultaneously after reset (1-byte packets) -> order 0 then 2. With all requesting continuously -> grant order 0,1,2,3,0.
- uart_tx_full held high for 20 cycles while owner 3 is valid -> no req_ready and no pulse. First pulse occurs 2 cycles after full drops (accept, then pulse).
- Owner 0 mid-packet, requester 1 valid; rst pulsed during GAP -> all outputs 0 asynchronously. After release, arbitration restarts from requester 0.
- With UART_TX_ARB_TIMEOUT_EN, IDLE_TIMEOUT=16:
  - Owner 2 sends a non-last byte then drops valid -> forced release after 16 idle cycles, timeout_flag=1, requester 3 granted next.
  - Without the macro, the same stimulus keeps grant=0100 indefinitely.
